// File: rtl/usb_hub_pkg.sv
// usb_hub_pkg -- definitions shared by the hub's serial receive path.
//   DATA_W     : default payload bits per frame
//   VALID_BIT  : index of the valid flag in the {valid, byte} word
//   rx_state_e : receiver FSM states
//   *_LVL      : serial line levels for start, stop and idle
package usb_hub_pkg;
    localparam int DATA_W    = 8;
    localparam int VALID_BIT = DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } rx_state_e;

    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;
    localparam logic IDLE_LVL  = 1'b0;
endpackage

// File: rtl/usb_serial_rx_if.sv
// usb_serial_rx_if -- serial line and byte-delivery signals of the receiver.
//   serial_in : serial line, idle low, one bit per clk
//   rx_data   : {valid, byte} head of the receive buffer
//   rx_ack    : pops the head entry while valid
//   frame_err : one-cycle pulse on a bad stop bit
//   overrun   : one-cycle pulse when a good frame finds the buffer full
//   busy      : a frame is in progress
// slave is the receiver side, master is the line driver / byte consumer.
interface usb_serial_rx_if #(
    parameter int DATA_W = usb_hub_pkg::DATA_W
);
    logic              serial_in;
    logic [DATA_W:0]   rx_data;
    logic              rx_ack;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    modport slave (
        input  serial_in, rx_ack,
        output rx_data, frame_err, overrun, busy
    );

    modport master (
        output serial_in, rx_ack,
        input  rx_data, frame_err, overrun, busy
    );
endinterface

// File: rtl/usb_rx_buf2.sv
// usb_rx_buf2 -- two-entry FIFO holding received bytes.
//   clk, rst : clock, synchronous active-high reset
//   wr_en    : write request (ignored when full unless a read frees a slot)
//   wr_data  : byte to write
//   rd_en    : pop request (ignored when empty)
//   rd_data  : head entry (slot[rd_ptr])
//   count    : occupancy 0..2
//   full     : count == 2
//   empty    : count == 0
module usb_rx_buf2 #(
    parameter int DATA_W = usb_hub_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        count,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] slot [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic              rd_ok;
    logic              wr_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign rd_data = slot[rd_ptr];

    // A pop in the same cycle frees a slot, so a write into a full buffer
    // still succeeds when it coincides with a read.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (wr_ok) begin
                slot[wr_ptr] <= wr_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (rd_ok)
                rd_ptr <= ~rd_ptr;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/usb_serial_rx.sv
// usb_serial_rx -- receive end of the hub's byte-serial link.
// Frame: start bit (1), DATA_W data bits LSB first, stop bit (0).
// Good frames go into a two-entry FIFO presented as {valid, byte}.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : usb_serial_rx_if.slave (serial_in, rx_ack in; rx_data,
//          frame_err, overrun, busy out)
module usb_serial_rx #(
    parameter int DATA_W = usb_hub_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    usb_serial_rx_if.slave     bus
);
    import usb_hub_pkg::*;

    localparam int CNT_W = $clog2(DATA_W) + 1;

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               commit;
    logic               bad_stop;
    logic               frame_err_q;
    logic               overrun_q;

    logic [DATA_W-1:0]  rd_data;
    logic [1:0]         count;
    logic               full;
    logic               empty;
    logic               pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        commit    = 1'b0;
        bad_stop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.serial_in == START_LVL) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                // LSB first: new bits enter at the top and walk down.
                shift_d   = {bus.serial_in, shift_q[DATA_W-1:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_W'(DATA_W - 1))
                    state_d = STOP;
            end
            STOP: begin
                // A high stop bit is only an error; it never doubles as
                // the next start bit.
                state_d = IDLE;
                if (bus.serial_in == STOP_LVL)
                    commit = 1'b1;
                else
                    bad_stop = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop = bus.rx_ack && !empty;

    usb_rx_buf2 #(.DATA_W(DATA_W)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (commit),
        .wr_data (shift_q),
        .rd_en   (bus.rx_ack),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= bad_stop;
            overrun_q   <= commit && full && !pop;
        end
    end

    assign bus.rx_data   = empty ? '0 : {1'b1, rd_data};
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q != IDLE);

    logic unused_count;
    assign unused_count = ^count;
endmodule

// File: tb/tb_usb_serial_rx.sv
// tb_usb_serial_rx -- randomized scoreboard bench for usb_serial_rx.
// The driver issues frames/idle cycles and keeps a queue-level model of
// the receive buffer; a separate negedge monitor compares the DUT outputs
// against that model and pops delivered bytes from a scoreboard queue.
module tb_usb_serial_rx;
    import usb_hub_pkg::*;

    logic clk = 1'b0;
    logic rst;

    usb_serial_rx_if bus ();

    usb_serial_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    bit         rand_ack = 1'b0;
    logic [7:0] q[$];      // model buffer contents, head first
    logic [7:0] sb_q[$];   // bytes expected to be delivered, in order
    bit         exp_fe, exp_ov, exp_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rack();
        return rand_ack && ($urandom_range(0, 2) == 0);
    endfunction

    // One clock edge: drive inputs, then advance the model.
    // ev: 0 none, 1 good stop sampled, 2 bad stop sampled.
    task automatic edge1(input logic sin, input logic ack, input logic r,
                         input bit bsy, input int ev, input logic [7:0] b);
        bus.serial_in = sin;
        bus.rx_ack    = ack;
        rst           = r;
        @(posedge clk);
        if (r) begin
            q.delete();
            sb_q.delete();
            exp_fe   = 1'b0;
            exp_ov   = 1'b0;
            exp_busy = 1'b0;
        end else begin
            exp_fe   = (ev == 2);
            exp_ov   = 1'b0;
            exp_busy = bsy;
            if (ack && q.size() > 0)
                q.delete(0);
            if (ev == 1) begin
                if (q.size() < 2) begin
                    q.push_back(b);
                    sb_q.push_back(b);
                end else begin
                    exp_ov = 1'b1;
                end
            end
        end
        mon_en = 1'b1;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) edge1(IDLE_LVL, rack(), 1'b0, 1'b0, 0, 8'h00);
    endtask

    task automatic ack1();
        edge1(IDLE_LVL, 1'b1, 1'b0, 1'b0, 0, 8'h00);
    endtask

    task automatic frame(input logic [7:0] b, input bit bad, input bit ack_stop);
        edge1(START_LVL, rack(), 1'b0, 1'b1, 0, 8'h00);
        for (int i = 0; i < 8; i++)
            edge1(b[i], rack(), 1'b0, 1'b1, 0, 8'h00);
        edge1(bad ? 1'b1 : STOP_LVL, ack_stop | rack(), 1'b0, 1'b0, bad ? 2 : 1, b);
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (mon_en) begin
            e = (q.size() > 0) ? {1'b1, q[0]} : 9'h000;
            chk("rx_data",   32'(bus.rx_data),   32'(e));
            chk("frame_err", 32'(bus.frame_err), 32'(exp_fe));
            chk("overrun",   32'(bus.overrun),   32'(exp_ov));
            chk("busy",      32'(bus.busy),      32'(exp_busy));
            if (bus.rx_data[VALID_BIT] && bus.rx_ack) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_pop: got byte %0h expected none", bus.rx_data[7:0]);
                end else begin
                    chk("sb_byte", 32'(bus.rx_data[7:0]), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        // reset
        edge1(1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00);
        edge1(1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00);
        idle(1);

        // single frame
        frame(8'hA5, 1'b0, 1'b0);
        idle(2);
        ack1();
        idle(1);

        // back-to-back identical bytes, then drain
        frame(8'h3C, 1'b0, 1'b0);
        frame(8'h3C, 1'b0, 1'b0);
        idle(1);
        ack1();
        idle(1);
        ack1();
        idle(1);

        // overrun, then commit into full buffer with simultaneous pop
        frame(8'h11, 1'b0, 1'b0);
        frame(8'h22, 1'b0, 1'b0);
        frame(8'h33, 1'b0, 1'b0);
        idle(2);
        frame(8'h33, 1'b0, 1'b1);
        idle(1);
        ack1();
        ack1();
        ack1();
        idle(1);

        // bad stop bit, then a good frame; also commit+pop at count 1
        frame(8'h5A, 1'b1, 1'b0);
        idle(1);
        frame(8'h01, 1'b0, 1'b0);
        frame(8'h02, 1'b0, 1'b1);
        idle(1);
        frame(8'h5A, 1'b1, 1'b0);
        frame(8'h03, 1'b0, 1'b0);
        idle(1);

        // reset mid-frame of 0xFF
        edge1(START_LVL, 1'b0, 1'b0, 1'b1, 0, 8'h00);
        repeat (4) edge1(1'b1, 1'b0, 1'b0, 1'b1, 0, 8'h00);
        edge1(1'b1, 1'b0, 1'b1, 1'b0, 0, 8'h00);
        idle(1);
        frame(8'h80, 1'b0, 1'b0);
        idle(1);
        ack1();

        // acks while empty
        for (int i = 0; i < 6; i++)
            edge1(IDLE_LVL, 1'(i % 2), 1'b0, 1'b0, 0, 8'h00);

        // randomized traffic
        rand_ack = 1'b1;
        repeat (60) begin
            idle($urandom_range(0, 3));
            frame(8'($urandom), $urandom_range(0, 6) == 0, 1'b0);
        end
        rand_ack = 1'b0;
        repeat (3) ack1();
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
